// File: rtl/led_demux_scan.sv
// LED demultiplexer with four behaviours selected by 'mode':
// direct demux, sticky latch store, circular scan and ping-pong (bounce) scan.
// Every output comes from a register, so the response appears one clock
// after the inputs are sampled.
module led_demux_scan #(
  parameter int N_CH     = 4,
  parameter int SEL_W    = 2,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             data_in,
  input  logic [SEL_W-1:0] sw,
  input  logic [1:0]       mode,
  input  logic             clr,
  output logic [N_CH-1:0]  led,
  output logic [SEL_W-1:0] active_ch,
  output logic             wrap
);

  localparam int               PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    P_LAST  = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]    P_ONE   = PW'(1);
  localparam logic [SEL_W:0]   N_CH_X  = (SEL_W + 1)'(N_CH);
  localparam logic [SEL_W-1:0] CH_LAST = SEL_W'(N_CH - 1);
  localparam logic [SEL_W-1:0] CH_ONE  = SEL_W'(1);
  localparam logic [SEL_W-1:0] CH_ZERO = SEL_W'(0);

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_LATCH  = 2'b01,
    MODE_SCAN   = 2'b10,
    MODE_BOUNCE = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // One-hot decode; indices at or above N_CH decode to all-zero.
  function automatic logic [N_CH-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_CH-1:0] r;
    r = '0;
    for (int i = 0; i < N_CH; i++) begin
      r[i] = (idx == SEL_W'(i));
    end
    return r;
  endfunction

  logic [N_CH-1:0]  led_q, led_d;
  logic [SEL_W-1:0] active_q, active_d;
  logic             wrap_q, wrap_d;
  logic [N_CH-1:0]  store_q, store_d;
  logic [PW-1:0]    presc_q, presc_d;
  dir_e             dir_q, dir_d;
  mode_e            mode_q, mode_d;

  mode_e            mode_s;
  logic             sw_ok_s;
  logic             mode_chg_s;
  logic             term_s;
  logic [SEL_W-1:0] scan_nxt_s;
  logic [SEL_W-1:0] bnc_nxt_s;
  dir_e             bnc_dir_s;

  assign mode_s     = mode_e'(mode);
  assign sw_ok_s    = ({1'b0, sw} < N_CH_X);
  assign mode_chg_s = (mode_s != mode_q);
  assign term_s     = (presc_q == P_LAST);

  // Next channel for both scan styles; clamped so no index reaches N_CH.
  always_comb begin
    scan_nxt_s = CH_ZERO;
    bnc_nxt_s  = CH_ZERO;
    bnc_dir_s  = dir_q;
    if (active_q >= CH_LAST) begin
      scan_nxt_s = CH_ZERO;
    end else begin
      scan_nxt_s = active_q + CH_ONE;
    end
    if (N_CH == 1) begin
      bnc_nxt_s = CH_ZERO;
    end else if (dir_q == DIR_UP) begin
      bnc_nxt_s = (active_q >= CH_LAST) ? active_q - CH_ONE : active_q + CH_ONE;
    end else begin
      bnc_nxt_s = (active_q == CH_ZERO) ? active_q + CH_ONE : active_q - CH_ONE;
    end
    // Direction flips on arriving at an end point; otherwise follows the step.
    if (bnc_nxt_s == CH_LAST) begin
      bnc_dir_s = DIR_DOWN;
    end else if (bnc_nxt_s == CH_ZERO) begin
      bnc_dir_s = DIR_UP;
    end else if (bnc_nxt_s > active_q) begin
      bnc_dir_s = DIR_UP;
    end else begin
      bnc_dir_s = DIR_DOWN;
    end
  end

  // Next-state for store, prescaler, channel, direction and the output image.
  always_comb begin
    store_d  = store_q;
    presc_d  = presc_q;
    active_d = active_q;
    dir_d    = dir_q;
    wrap_d   = 1'b0;
    led_d    = '0;
    mode_d   = mode_s;

    // Clear beats a simultaneous set; the store survives mode changes.
    if (clr) begin
      store_d = '0;
    end else if ((mode_s == MODE_LATCH) && data_in && sw_ok_s) begin
      store_d = store_q | onehot(sw);
    end else begin
      store_d = store_q;
    end

    if (mode_chg_s) begin
      presc_d  = '0;
      active_d = sw_ok_s ? sw : CH_ZERO;
      dir_d    = DIR_UP;
    end else begin
      case (mode_s)
        MODE_DIRECT, MODE_LATCH: begin
          presc_d = '0;
          if (sw_ok_s) begin
            active_d = sw;
          end else begin
            active_d = active_q;
          end
        end
        MODE_SCAN: begin
          if (term_s) begin
            presc_d  = '0;
            active_d = scan_nxt_s;
            wrap_d   = (active_q >= CH_LAST);
          end else begin
            presc_d  = presc_q + P_ONE;
          end
        end
        MODE_BOUNCE: begin
          if (term_s) begin
            presc_d  = '0;
            active_d = bnc_nxt_s;
            dir_d    = bnc_dir_s;
            wrap_d   = (bnc_nxt_s == CH_ZERO) || (bnc_nxt_s == CH_LAST);
          end else begin
            presc_d  = presc_q + P_ONE;
          end
        end
        default: begin
          presc_d  = '0;
          active_d = CH_ZERO;
        end
      endcase
    end

    case (mode_s)
      MODE_DIRECT: led_d = sw_ok_s ? (onehot(sw) & {N_CH{data_in}}) : '0;
      MODE_LATCH:  led_d = store_d;
      MODE_SCAN,
      MODE_BOUNCE: led_d = onehot(active_d) & {N_CH{data_in}};
      default:     led_d = '0;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led_q    <= '0;
      active_q <= CH_ZERO;
      wrap_q   <= 1'b0;
      store_q  <= '0;
      presc_q  <= '0;
      dir_q    <= DIR_UP;
      mode_q   <= MODE_DIRECT;
    end else begin
      led_q    <= led_d;
      active_q <= active_d;
      wrap_q   <= wrap_d;
      store_q  <= store_d;
      presc_q  <= presc_d;
      dir_q    <= dir_d;
      mode_q   <= mode_d;
    end
  end

  assign led       = led_q;
  assign active_ch = active_q;
  assign wrap      = wrap_q;

endmodule

// File: doc/led_demux_scan.md
LED_DEMUX_SCAN -- requirements
Module: led_demux_scan

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of output channels (legal range 1..64).
REQ-002 SHALL have parameter SEL_W, default 2, select width; SEL_W = max(1, ceil(log2(N_CH))).
REQ-003 SHALL have parameter PRESCALE, default 4, clock cycles per scan step (legal range 1..2^24).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port data_in  input  1  demux data bit (the DEMUX input).
REQ-007 SHALL have port sw  input  SEL_W  channel select (switches).
REQ-008 SHALL have port mode  input  2  operating mode: 00 DIRECT, 01 LATCH, 10 SCAN, 11 BOUNCE.
REQ-009 SHALL have port clr  input  1  clears the LATCH store.
REQ-010 SHALL have port led  output  N_CH  registered channel outputs.
REQ-011 SHALL have port active_ch  output  SEL_W  index of the channel currently driven.
REQ-012 SHALL have port wrap  output  1  one-cycle pulse at a scan end point.

Function
REQ-013 All outputs SHALL be registered; the response to any input appears 1 cycle after it is sampled.
REQ-014 DIRECT: led SHALL become one-hot(sw) AND data_in, with active_ch = sw.
REQ-015 DIRECT: if sw >= N_CH, led SHALL be all-zero and active_ch SHALL hold its previous value.
REQ-016 LATCH: when data_in = 1 and sw < N_CH, bit sw of the store SHALL be set, sticky; led SHALL equal the store.
REQ-017 LATCH: clr = 1 SHALL zero the store; if clr and a set occur in the same cycle, clr SHALL win.
REQ-018 LATCH: sw >= N_CH SHALL be ignored; active_ch = sw when sw is in range.
REQ-019 SCAN: a prescaler SHALL count 0..PRESCALE-1; at terminal count active_ch SHALL advance by 1 and wrap N_CH-1 -> 0.
REQ-020 SCAN: led SHALL be one-hot(active_ch) gated by data_in, so data_in = 0 blanks the LEDs without stopping the scan.
REQ-021 SCAN: wrap SHALL pulse for 1 cycle when the N_CH-1 -> 0 step occurs.
REQ-022 BOUNCE: active_ch SHALL step up to N_CH-1, then down to 0, and repeat; each end point SHALL be held for exactly one step.
REQ-023 BOUNCE: led SHALL follow the same gating as REQ-020, and wrap SHALL pulse on arrival at either end point.
REQ-024 A direction flag (UP/DOWN) SHALL be kept for BOUNCE; it SHALL flip on reaching either end point.
REQ-025 Any change of mode SHALL clear the prescaler and load active_ch = sw (0 if out of range), and set direction = UP.
REQ-026 When N_CH = 1, SCAN and BOUNCE SHALL hold active_ch = 0, and wrap SHALL pulse every PRESCALE cycles.
REQ-027 When PRESCALE = 1, active_ch SHALL step every cycle.
REQ-028 The LATCH store SHALL persist across mode changes; only clr or reset clears it.
REQ-029 Arithmetic SHALL never produce an active_ch >= N_CH.

Reset
REQ-030 While rst_n = 0 at a clock edge: led = 0, active_ch = 0, wrap = 0, store = 0, prescaler = 0, direction = UP, and the registered previous mode = DIRECT.
REQ-031 A reset asserted mid-scan SHALL take effect at the next edge; after release, counting SHALL restart from prescaler 0 and channel 0.

Verification
REQ-032 Reset: hold rst_n = 0 for 2 cycles with mode = 10 and data_in = 1 -> led = 0000, active_ch = 0, wrap = 0.
REQ-033 DIRECT: data_in = 1, sw = 2 -> led = 0100 one cycle later; then data_in = 0 -> led = 0000.
REQ-034 LATCH: pulse data_in with sw = 0, then sw = 3 -> led = 1001; assert clr together with a set -> led = 0000.
REQ-035 SCAN, PRESCALE = 4, N_CH = 4, data_in = 1 -> led follows 0001, 0010, 0100, 1000, 0001, each held 4 cycles, with a wrap pulse on the 1000 -> 0001 step.
REQ-036 BOUNCE, PRESCALE = 1 -> active_ch follows 0, 1, 2, 3, 2, 1, 0, 1, with wrap at 3 and at 0.
REQ-037 Parameter sweep: N_CH = 3 with sw = 3 in DIRECT -> led = 000; N_CH = 1 in SCAN -> led = 1, wrap every PRESCALE cycles.
